// File: rtl/serial_add_pkg.sv
// Shared constants for the bit-serial adder: FSM state encoding and WIDTH limits.
package serial_add_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;

endpackage

// File: rtl/serial_add_ctrl_fa_bit.sv
// Combinational 1-bit full adder cell shared by every bit position of the serial add.
module fa_bit (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: one fa_bit cell adds WIDTH-bit operands LSB-first.
// Optional macro SERIAL_ADD_OVF_EN adds a registered two's-complement overflow output.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
`ifdef SERIAL_ADD_OVF_EN
    output logic             ovf,
`endif
    output logic [1:0]       dbg_state
);

    // Handshake: start is accepted on any edge where state is IDLE or DONE (start
    // behaves as valid, "not busy" as ready); busy covers the WIDTH RUN cycles, and
    // done pulses for one cycle while sum/cout/ovf hold the new result.
    localparam int              CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             c;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;
    logic [WIDTH-1:0] res_next;

    assign dbg_state = state;

    fa_bit u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (c),
        .s  (fa_s),
        .co (fa_co)
    );

    // Result bits refill the MSB end of a_sh as operand bits are consumed, so after
    // WIDTH shifts a_sh holds the sum without a separate result shifter.
    generate
        if (WIDTH == 1) begin : g_w1
            assign res_next = fa_s;
        end else begin : g_wn
            assign res_next = {fa_s, a_sh[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            a_sh  <= '0;
            b_sh  <= '0;
            c     <= 1'b0;
            cnt   <= '0;
`ifdef SERIAL_ADD_OVF_EN
            ovf   <= 1'b0;
`endif
        end else begin
            case (state)
                S_RUN: begin
                    a_sh <= res_next;
                    b_sh <= b_sh >> 1;
                    c    <= fa_co;
                    cnt  <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        sum   <= res_next;
                        cout  <= fa_co;
`ifdef SERIAL_ADD_OVF_EN
                        ovf   <= c ^ fa_co;
`endif
                    end
                end
                default: begin
                    done <= 1'b0;
                    if (start) begin
                        state <= S_RUN;
                        busy  <= 1'b1;
                        a_sh  <= a;
                        b_sh  <= b;
                        c     <= cin;
                        cnt   <= '0;
                    end else begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end
                end
            endcase
        end
    end

endmodule
